ibex_rf_wr_arbiter: RTL and testbench
=====================================

IBEX_RF_WR_ARBITER -- requirements
Module: ibex_rf_wr_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of ID write-buffer entries (legal range 1..4).
REQ-002 SHALL use one clock and a synchronous, active-high reset.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port id_req_i, input, 1 bit: ID/EX result write request.
REQ-006 SHALL have port id_waddr_i, input, 5 bits: ID write address.
REQ-007 SHALL have port id_wdata_i, input, 32 bits: ID write data.
REQ-008 SHALL have port id_gnt_o, output, 1 bit: ID request accepted this cycle.
REQ-009 SHALL have port lsu_req_i, input, 1 bit: load-data write request; the LSU has no backpressure.
REQ-010 SHALL have port lsu_waddr_i, input, 5 bits: load write address.
REQ-011 SHALL have port lsu_wdata_i, input, 32 bits: load write data.
REQ-012 SHALL have port rf_we_o, input-to-RF output, 1 bit: register-file write enable.
REQ-013 SHALL have port rf_waddr_o, output, 5 bits: register-file write address.
REQ-014 SHALL have port rf_wdata_o, output, 32 bits: register-file write data.
REQ-015 SHALL have port fwd_raddr_i, input, 5 bits: operand address to check against buffered writes.
REQ-016 SHALL have port fwd_hit_o, output, 1 bit: a buffered entry matches fwd_raddr_i.
REQ-017 SHALL have port fwd_data_o, output, 32 bits: data of the youngest matching entry; 0 when no hit.
REQ-018 SHALL have port buf_count_o, output, $clog2(DEPTH+1) bits: number of valid buffer entries.
REQ-019 SHALL have port idle_o, output, 1 bit: buf_count_o==0 and no lsu_req_i.

Function
REQ-020 SHALL give lsu_req_i absolute priority: when asserted, rf_we_o=1, rf_waddr_o=lsu_waddr_i, rf_wdata_o=lsu_wdata_i in the same cycle (zero latency).
REQ-021 SHALL drive id_gnt_o = id_req_i & (buf_count_o < DEPTH) & ~rst_i. Grant does not depend on a same-cycle pop: a full buffer refuses the request even while draining.
REQ-022 SHALL, when an ID request is granted, the buffer is empty and lsu_req_i=0, write it directly to the RF that cycle (bypass) without storing it.
REQ-023 SHALL otherwise push a granted ID request at the tail of the FIFO at the next clock edge.
REQ-024 SHALL, when lsu_req_i=0 and the buffer is non-empty, write the head entry to the RF and pop it. The new ID request is pushed in the same cycle (simultaneous push and pop, count unchanged).
REQ-025 SHALL write buffered entries strictly in acceptance order. Read and write pointers wrap modulo DEPTH.
REQ-026 SHALL treat an ID request with id_waddr_i==0 as granted under REQ-021 but discard it: no store, no RF write.
REQ-027 SHALL suppress rf_we_o for an LSU request with lsu_waddr_i==0; the port is still consumed that cycle.
REQ-028 SHALL perform an LSU write even when its address matches a buffered entry. The buffered (younger) entry is written later, so its value is final.
REQ-029 SHALL, when rf_we_o=0, drive rf_waddr_o=0 and rf_wdata_o=0.
REQ-030 SHALL compute fwd_hit_o and fwd_data_o combinationally over valid entries only. Youngest wins; fwd_raddr_i==0 never hits; the bypass write in REQ-022 is not a hit.
REQ-031 SHALL hold buffer contents unchanged while lsu_req_i is continuously asserted (starvation permitted; backpressure comes via id_gnt_o).

Reset
REQ-032 SHALL, while rst_i=1, force id_gnt_o=0, rf_we_o=0, fwd_hit_o=0, fwd_data_o=0.
REQ-033 SHALL, at a clock edge with rst_i=1, clear all valid bits, both pointers and buf_count_o to 0. This discards buffered writes mid-operation.
REQ-034 SHALL present buf_count_o=0 and idle_o=1 in the first cycle after reset deasserts (absent lsu_req_i).

Verification
REQ-035 Bypass: empty buffer, id_req x5 data 0xA5A5A5A5, no LSU -> same-cycle rf_we=1, waddr=5, wdata=0xA5A5A5A5, count stays 0.
REQ-036 Collision: id_req x3 and lsu_req x7 in the same cycle -> LSU written (x7); next cycle with no LSU, x3 written; count goes 1 then 0.
REQ-037 Full: DEPTH=2, lsu_req held 3 cycles with id_req each cycle x1,x2,x4 -> grants 1,1,0; count=2; after LSU drops, x1 then x2 are written in order.
REQ-038 Forwarding: buffer holds x6=0x11 then x6=0x22, fwd_raddr=6 -> hit=1, data=0x22. With fwd_raddr=0 -> hit=0.
REQ-039 x0 discard: id_req x0 with lsu_req active -> gnt=1, count stays 0, no later RF write.
REQ-040 Reset mid-operation: count=2, assert rst_i for one edge -> count=0, gnt=0 during reset, no pending write after release.

Source files
------------

// File: rtl/ibex_rf_wr_arbiter.sv
// Register-file write-port arbiter: LSU load data has absolute priority and
// ID/EX results are buffered in a small in-order FIFO with operand forwarding.
module ibex_rf_wr_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       id_req_i,
  input  logic [4:0]                 id_waddr_i,
  input  logic [31:0]                id_wdata_i,
  output logic                       id_gnt_o,
  input  logic                       lsu_req_i,
  input  logic [4:0]                 lsu_waddr_i,
  input  logic [31:0]                lsu_wdata_i,
  output logic                       rf_we_o,
  output logic [4:0]                 rf_waddr_o,
  output logic [31:0]                rf_wdata_o,
  input  logic [4:0]                 fwd_raddr_i,
  output logic                       fwd_hit_o,
  output logic [31:0]                fwd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] buf_count_o,
  output logic                       idle_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: id_gnt_o is a same-cycle acceptance of id_req_i; an accepted
  // request is either written through, stored, or (for x0) dropped. The LSU
  // port has no ready signal and is always consumed in the cycle it is valid.

  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [4:0]              addr_q [DEPTH];
  logic [4:0]              addr_d [DEPTH];
  logic [31:0]             data_q [DEPTH];
  logic [31:0]             data_d [DEPTH];
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  logic                    buf_empty;
  logic                    buf_full;
  logic                    id_gnt;
  logic                    id_keep;
  logic                    bypass;
  logic                    push;
  logic                    pop;

  always_comb begin
    buf_empty = (count_q == '0);
    buf_full  = (count_q >= CW'(DEPTH));
    id_gnt    = id_req_i & ~buf_full & ~rst_i;
    // Writes to x0 are accepted but have no architectural effect.
    id_keep   = id_gnt & (id_waddr_i != 5'd0);
    bypass    = id_keep & buf_empty & ~lsu_req_i;
    push      = id_keep & ~bypass;
    pop       = ~lsu_req_i & ~buf_empty & ~rst_i;
  end

  assign id_gnt_o    = id_gnt;
  assign buf_count_o = count_q;
  assign idle_o      = buf_empty & ~lsu_req_i;

  // RF write mux: LSU first, then oldest buffered entry, then bypass.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    if (!rst_i) begin
      if (lsu_req_i) begin
        if (lsu_waddr_i != 5'd0) begin
          rf_we_o    = 1'b1;
          rf_waddr_o = lsu_waddr_i;
          rf_wdata_o = lsu_wdata_i;
        end
      end else if (!buf_empty) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = addr_q[rd_ptr_q];
        rf_wdata_o = data_q[rd_ptr_q];
      end else if (bypass) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = id_waddr_i;
        rf_wdata_o = id_wdata_i;
      end
    end
  end

  // Forwarding walks entries oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW:0] idx;
    fwd_hit_o  = 1'b0;
    fwd_data_o = 32'd0;
    idx        = '0;
    if (!rst_i && fwd_raddr_i != 5'd0) begin
      for (int k = 0; k < DEPTH; k++) begin
        idx = {1'b0, rd_ptr_q} + (PW+1)'(k);
        if (idx >= (PW+1)'(DEPTH)) begin
          idx = idx - (PW+1)'(DEPTH);
        end
        if (valid_q[idx[PW-1:0]] && addr_q[idx[PW-1:0]] == fwd_raddr_i) begin
          fwd_hit_o  = 1'b1;
          fwd_data_o = data_q[idx[PW-1:0]];
        end
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (rst_i) begin
      valid_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      // Push after pop so a full-then-drained slot is never clobbered early.
      if (push) begin
        valid_d[wr_ptr_q] = 1'b1;
        addr_d[wr_ptr_q]  = id_waddr_i;
        data_d[wr_ptr_q]  = id_wdata_i;
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    valid_q  <= valid_d;
    addr_q   <= addr_d;
    data_q   <= data_d;
    rd_ptr_q <= rd_ptr_d;
    wr_ptr_q <= wr_ptr_d;
    count_q  <= count_d;
  end

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// Self-checking bench for ibex_rf_wr_arbiter: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_ibex_rf_wr_arbiter;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          id_req;
  logic [4:0]    id_waddr;
  logic [31:0]   id_wdata;
  logic          id_gnt;
  logic          lsu_req;
  logic [4:0]    lsu_waddr;
  logic [31:0]   lsu_wdata;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [4:0]    fwd_raddr;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [CW-1:0] buf_count;
  logic          idle;

  int errors = 0;
  int checks = 0;

  // Reference model: pending ID writes in acceptance order, {addr, data}.
  logic [36:0] exp_q[$];

  // Observations captured at the last checked cycle, for directed checks.
  logic        s_gnt, s_we, s_hit, s_idle;
  logic [4:0]  s_waddr;
  logic [31:0] s_wdata, s_fdata;
  int          s_count;

  ibex_rf_wr_arbiter #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .id_req_i    (id_req),
    .id_waddr_i  (id_waddr),
    .id_wdata_i  (id_wdata),
    .id_gnt_o    (id_gnt),
    .lsu_req_i   (lsu_req),
    .lsu_waddr_i (lsu_waddr),
    .lsu_wdata_i (lsu_wdata),
    .rf_we_o     (rf_we),
    .rf_waddr_o  (rf_waddr),
    .rf_wdata_o  (rf_wdata),
    .fwd_raddr_i (fwd_raddr),
    .fwd_hit_o   (fwd_hit),
    .fwd_data_o  (fwd_data),
    .buf_count_o (buf_count),
    .idle_o      (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: apply inputs, check outputs against the model mid-cycle,
  // then advance the model at the rising edge.
  task automatic step(input logic r, input logic ir, input logic [4:0] ia, input logic [31:0] id,
                      input logic lr, input logic [4:0] la, input logic [31:0] ld,
                      input logic [4:0] fa);
    logic        e_gnt, e_we, e_hit, e_byp;
    logic [4:0]  e_wa;
    logic [31:0] e_wd, e_fd;
    int          sz;
    rst = r; id_req = ir; id_waddr = ia; id_wdata = id;
    lsu_req = lr; lsu_waddr = la; lsu_wdata = ld; fwd_raddr = fa;
    @(negedge clk);
    sz    = exp_q.size();
    e_gnt = ir && (sz < DEPTH) && !r;
    e_byp = e_gnt && ia != 0 && sz == 0 && !lr;
    e_we = 0; e_wa = 0; e_wd = 0; e_hit = 0; e_fd = 0;
    if (!r) begin
      if (lr) begin
        if (la != 0) begin e_we = 1; e_wa = la; e_wd = ld; end
      end else if (sz > 0) begin
        e_we = 1; e_wa = exp_q[0][36:32]; e_wd = exp_q[0][31:0];
      end else if (e_byp) begin
        e_we = 1; e_wa = ia; e_wd = id;
      end
      if (fa != 0) begin
        for (int i = 0; i < sz; i++) begin
          if (exp_q[i][36:32] == fa) begin e_hit = 1; e_fd = exp_q[i][31:0]; end
        end
      end
    end
    check("gnt",      32'(id_gnt),    32'(e_gnt));
    check("rf_we",    32'(rf_we),     32'(e_we));
    check("rf_waddr", 32'(rf_waddr),  32'(e_wa));
    check("rf_wdata", rf_wdata,       e_wd);
    check("fwd_hit",  32'(fwd_hit),   32'(e_hit));
    check("fwd_data", fwd_data,       e_fd);
    check("count",    32'(buf_count), 32'(sz));
    check("idle",     32'(idle),      32'(sz == 0 && !lr));
    s_gnt = id_gnt; s_we = rf_we; s_waddr = rf_waddr; s_wdata = rf_wdata;
    s_hit = fwd_hit; s_fdata = fwd_data; s_count = int'(buf_count); s_idle = idle;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
    end else begin
      if (!lr && sz > 0) void'(exp_q.pop_front());
      if (e_gnt && ia != 0 && !e_byp) exp_q.push_back({ia, id});
    end
    #1;
  endtask

  task automatic idle_cycle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; id_req = 0; id_waddr = 0; id_wdata = 0;
    lsu_req = 0; lsu_waddr = 0; lsu_wdata = 0; fwd_raddr = 0;
    // Reset: outputs forced while asserted, empty and idle after release.
    step(1, 1, 5'd3, 32'h1, 0, 0, 0, 5'd3);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_gnt", 32'(s_gnt), 32'd0);
    idle_cycle();
    check("post_rst_count", 32'(s_count), 32'd0);
    check("post_rst_idle",  32'(s_idle),  32'd1);

    // Bypass write on an empty buffer.
    step(0, 1, 5'd5, 32'hA5A5A5A5, 0, 0, 0, 5'd5);
    check("byp_we",    32'(s_we),    32'd1);
    check("byp_waddr", 32'(s_waddr), 32'd5);
    check("byp_wdata", s_wdata,      32'hA5A5A5A5);
    check("byp_hit",   32'(s_hit),   32'd0);
    idle_cycle();
    check("byp_count", 32'(s_count), 32'd0);

    // Collision: LSU wins, ID write follows next cycle.
    step(0, 1, 5'd3, 32'h33, 1, 5'd7, 32'h77, 0);
    check("col_waddr", 32'(s_waddr), 32'd7);
    idle_cycle();
    check("col_count1", 32'(s_count), 32'd1);
    check("col_waddr2", 32'(s_waddr), 32'd3);
    idle_cycle();
    check("col_count0", 32'(s_count), 32'd0);

    // Full buffer under sustained LSU traffic.
    step(0, 1, 5'd1, 32'h101, 1, 5'd9, 32'h9, 0);
    check("full_gnt0", 32'(s_gnt), 32'd1);
    step(0, 1, 5'd2, 32'h102, 1, 5'd10, 32'hA, 0);
    check("full_gnt1", 32'(s_gnt), 32'd1);
    step(0, 1, 5'd4, 32'h104, 1, 5'd11, 32'hB, 0);
    check("full_gnt2", 32'(s_gnt), 32'd0);
    idle_cycle();
    check("full_count", 32'(s_count), 32'd2);
    check("full_wr1",   32'(s_waddr), 32'd1);
    idle_cycle();
    check("full_wr2",   32'(s_waddr), 32'd2);
    idle_cycle();

    // Forwarding: youngest match wins, x0 never hits.
    step(0, 1, 5'd6, 32'h11, 1, 5'd12, 32'hC, 0);
    step(0, 1, 5'd6, 32'h22, 1, 5'd13, 32'hD, 0);
    step(0, 0, 0, 0, 1, 5'd14, 32'hE, 5'd6);
    check("fwd_hit6",  32'(s_hit), 32'd1);
    check("fwd_data6", s_fdata,    32'h22);
    step(0, 0, 0, 0, 1, 5'd14, 32'hE, 5'd0);
    check("fwd_hit0",  32'(s_hit), 32'd0);
    idle_cycle();
    idle_cycle();
    idle_cycle();

    // x0 discard while LSU is active.
    step(0, 1, 5'd0, 32'hDEAD, 1, 5'd15, 32'hF, 0);
    check("x0_gnt", 32'(s_gnt), 32'd1);
    idle_cycle();
    check("x0_count", 32'(s_count), 32'd0);
    check("x0_we",    32'(s_we),    32'd0);

    // LSU to x0 is consumed without a write.
    step(0, 0, 0, 0, 1, 5'd0, 32'h1234, 0);
    check("lsu_x0_we", 32'(s_we), 32'd0);

    // Reset with two buffered writes pending.
    step(0, 1, 5'd20, 32'h20, 1, 5'd21, 32'h21, 0);
    step(0, 1, 5'd22, 32'h22, 1, 5'd21, 32'h21, 0);
    step(1, 1, 5'd23, 32'h23, 0, 0, 0, 5'd20);
    check("rst_mid_count_pre", 32'(s_count), 32'd2);
    check("rst_mid_gnt",       32'(s_gnt),   32'd0);
    check("rst_mid_we",        32'(s_we),    32'd0);
    idle_cycle();
    check("rst_mid_count", 32'(s_count), 32'd0);
    check("rst_mid_pend",  32'(s_we),    32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
